// File: rtl/swap_scheduler_pkg.sv
// Package swap_sched_pkg
// Shared types and constants for the swap scheduler slice.
//   NUM_REGS / REG_W / FIFO_DEPTH : default geometry. swap_cmd_t takes its
//                                   field width from REG_W here, so a
//                                   different register count is made by
//                                   editing this package.
//   swap_cmd_t                    : one queued swap (two register indices)
//   issue_src_e                   : where the next issued swap comes from
//   IDENTITY_MAP                  : flattened identity permutation, slice i = i
package swap_sched_pkg;

    localparam int NUM_REGS   = 4;
    localparam int REG_W      = $clog2(NUM_REGS);
    localparam int FIFO_DEPTH = 4;

    typedef struct packed {
        logic [REG_W-1:0] a;
        logic [REG_W-1:0] b;
    } swap_cmd_t;

    typedef enum logic [1:0] {
        ISSUE_NONE = 2'd0,
        ISSUE_CPU  = 2'd1,
        ISSUE_FIFO = 2'd2
    } issue_src_e;

    // Builds the flattened identity permutation used as the reset mapping.
    function automatic logic [NUM_REGS*REG_W-1:0] identityMap();
        logic [NUM_REGS*REG_W-1:0] m;
        m = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            m[i*REG_W +: REG_W] = REG_W'(i);
        end
        return m;
    endfunction

    localparam logic [NUM_REGS*REG_W-1:0] IDENTITY_MAP = identityMap();

endpackage

// File: rtl/swap_scheduler_fifo.sv
// Module swap_cmd_fifo
// Synchronous FIFO of swap_cmd_t with a flush that empties it at the next edge.
// Ports:
//   clk_i, reset_i : clock, asynchronous active-high reset
//   flush_i        : drop every entry at the next edge; blocks push and pop
//   push_i, data_i : write one command (ignored when full)
//   pop_i,  data_o : remove the head; data_o always shows the current head
//   count_o        : number of entries held (0..DEPTH)
//   full_o, empty_o: occupancy flags
// DEPTH must be a power of two so the pointers wrap by plain overflow.
module swap_cmd_fifo
    import swap_sched_pkg::*;
#(
    parameter  int DEPTH = FIFO_DEPTH,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             flush_i,
    input  logic             push_i,
    input  swap_cmd_t        data_i,
    input  logic             pop_i,
    output swap_cmd_t        data_o,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o,
    output logic             empty_o
);

    swap_cmd_t        mem_q [DEPTH];
    logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             doPush;
    logic             doPop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rdPtr_q];

    // Pointer and count next-state; flush wins over any push or pop.
    always_comb begin
        doPush  = push_i & ~full_o & ~flush_i;
        doPop   = pop_i & ~empty_o & ~flush_i;
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (flush_i) begin
            wrPtr_d = '0;
            rdPtr_d = '0;
            count_d = '0;
        end else begin
            if (doPush) begin
                wrPtr_d = wrPtr_q + PTR_W'(1);
            end
            if (doPop) begin
                rdPtr_d = rdPtr_q + PTR_W'(1);
            end
            case ({doPush, doPop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control registers.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

    // Storage; cleared on reset so the head never shows X.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (doPush) begin
            mem_q[wrPtr_q] <= data_i;
        end
    end

endmodule

// File: rtl/swap_scheduler.sv
// Module swap_scheduler
// Turns swap requests into the register mapper's doSWAP/reg1/reg2 strobe.
// Two background requesters share a round-robin grant into a command FIFO;
// a swap from decode preempts the FIFO for that cycle. A shadow copy of the
// mapping is updated exactly as the mapper does, so other blocks can read
// the current permutation from map_flat.
// Ports:
//   clk, reset               : clock, asynchronous active-high reset
//   req_valid/req_a/req_b    : per-requester swap request (slice i = requester i)
//   req_ready                : transfer happens when valid & ready
//   cpu_swap/cpu_reg1/2      : priority swap from decode
//   flush                    : empty the FIFO at the next edge
//   doSWAP/swap_reg1/2       : registered strobe and operands to the mapper
//   fifo_count, busy         : occupancy and activity
//   map_flat                 : shadow mapping, slice i = mapping[i]
// Optional macro SWAP_SCHED_STATS_EN adds stat_issued and stat_identity,
// 16-bit saturating counters of doSWAP cycles and dropped a==b requests.
module swap_scheduler #(
    parameter  int NUM_REGS   = swap_sched_pkg::NUM_REGS,
    parameter  int FIFO_DEPTH = swap_sched_pkg::FIFO_DEPTH,
    localparam int REG_W      = $clog2(NUM_REGS),
    localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [1:0]                req_valid,
    input  logic [2*REG_W-1:0]        req_a,
    input  logic [2*REG_W-1:0]        req_b,
    output logic [1:0]                req_ready,
    input  logic                      cpu_swap,
    input  logic [REG_W-1:0]          cpu_reg1,
    input  logic [REG_W-1:0]          cpu_reg2,
    input  logic                      flush,
    output logic                      doSWAP,
    output logic [REG_W-1:0]          swap_reg1,
    output logic [REG_W-1:0]          swap_reg2,
    output logic [CNT_W-1:0]          fifo_count,
    output logic                      busy,
    output logic [NUM_REGS*REG_W-1:0] map_flat
`ifdef SWAP_SCHED_STATS_EN
    ,
    output logic [15:0]               stat_issued,
    output logic [15:0]               stat_identity
`endif
);

    import swap_sched_pkg::*;

    logic             rrPtr_q, rrPtr_d;
    logic [1:0]       grant;
    logic             winIdx;
    logic             accepted;
    logic             identityReq;
    swap_cmd_t        winCmd;
    swap_cmd_t        headCmd;
    logic             fifoPush;
    logic             fifoPop;
    logic             fifoFull;
    logic             fifoEmpty;
    logic [CNT_W-1:0] fifoCount;
    issue_src_e       issueSrc;
    logic             doSwap_q, doSwap_d;
    logic [REG_W-1:0] swapReg1_q, swapReg1_d;
    logic [REG_W-1:0] swapReg2_q, swapReg2_d;
    logic [REG_W-1:0] map_q [NUM_REGS];
    logic [REG_W-1:0] map_d [NUM_REGS];

    // Round-robin grant: the pointed-at requester wins if valid, otherwise
    // the other one. Ready is withheld while full even if a pop is about to
    // free a slot, which keeps the ready path independent of the issue logic.
    always_comb begin
        grant = 2'b00;
        if (rrPtr_q == 1'b0) begin
            if (req_valid[0])      grant = 2'b01;
            else if (req_valid[1]) grant = 2'b10;
        end else begin
            if (req_valid[1])      grant = 2'b10;
            else if (req_valid[0]) grant = 2'b01;
        end
        req_ready = grant & {2{~fifoFull & ~flush}};
    end

    // Accepted request: a==b swaps are consumed but never queued; the
    // pointer still moves past the winner either way.
    always_comb begin
        winIdx      = req_ready[1];
        accepted    = |req_ready;
        winCmd.a    = winIdx ? req_a[2*REG_W-1:REG_W] : req_a[REG_W-1:0];
        winCmd.b    = winIdx ? req_b[2*REG_W-1:REG_W] : req_b[REG_W-1:0];
        identityReq = (winCmd.a == winCmd.b);
        fifoPush    = accepted & ~identityReq;
        rrPtr_d     = accepted ? ~winIdx : rrPtr_q;
    end

    swap_cmd_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .reset_i (reset),
        .flush_i (flush),
        .push_i  (fifoPush),
        .data_i  (winCmd),
        .pop_i   (fifoPop),
        .data_o  (headCmd),
        .count_o (fifoCount),
        .full_o  (fifoFull),
        .empty_o (fifoEmpty)
    );

    // Issue selection: decode first, then the FIFO head unless a flush is
    // discarding it. Operands hold their last value when nothing issues.
    always_comb begin
        issueSrc   = ISSUE_NONE;
        fifoPop    = 1'b0;
        doSwap_d   = 1'b0;
        swapReg1_d = swapReg1_q;
        swapReg2_d = swapReg2_q;
        if (cpu_swap) begin
            issueSrc = ISSUE_CPU;
        end else if (!fifoEmpty && !flush) begin
            issueSrc = ISSUE_FIFO;
        end
        case (issueSrc)
            ISSUE_CPU: begin
                doSwap_d   = 1'b1;
                swapReg1_d = cpu_reg1;
                swapReg2_d = cpu_reg2;
            end
            ISSUE_FIFO: begin
                fifoPop    = 1'b1;
                doSwap_d   = 1'b1;
                swapReg1_d = headCmd.a;
                swapReg2_d = headCmd.b;
            end
            default: begin
                doSwap_d = 1'b0;
            end
        endcase
    end

    // Shadow map follows the mapper: a strobe visible this cycle swaps the
    // two entries at the next edge (a==b leaves the map unchanged).
    always_comb begin
        map_d = map_q;
        if (doSwap_q) begin
            map_d[swapReg1_q] = map_q[swapReg2_q];
            map_d[swapReg2_q] = map_q[swapReg1_q];
        end
    end

    // Scheduler state registers; reset drops anything in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rrPtr_q    <= 1'b0;
            doSwap_q   <= 1'b0;
            swapReg1_q <= '0;
            swapReg2_q <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                map_q[i] <= IDENTITY_MAP[i*REG_W +: REG_W];
            end
        end else begin
            rrPtr_q    <= rrPtr_d;
            doSwap_q   <= doSwap_d;
            swapReg1_q <= swapReg1_d;
            swapReg2_q <= swapReg2_d;
            map_q      <= map_d;
        end
    end

    // Flatten the shadow map so slice i carries mapping[i].
    always_comb begin
        map_flat = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            map_flat[i*REG_W +: REG_W] = map_q[i];
        end
    end

    assign doSWAP     = doSwap_q;
    assign swap_reg1  = swapReg1_q;
    assign swap_reg2  = swapReg2_q;
    assign fifo_count = fifoCount;
    assign busy       = (fifoCount != '0) | doSwap_q;

`ifdef SWAP_SCHED_STATS_EN
    logic [15:0] statIssued_q, statIssued_d;
    logic [15:0] statIdentity_q, statIdentity_d;

    // Saturating counters; issued counts the strobe as it is launched so
    // the count already includes a doSWAP that is high this cycle.
    always_comb begin
        statIssued_d   = statIssued_q;
        statIdentity_d = statIdentity_q;
        if (doSwap_d && statIssued_q != 16'hFFFF) begin
            statIssued_d = statIssued_q + 16'd1;
        end
        if (accepted && identityReq && statIdentity_q != 16'hFFFF) begin
            statIdentity_d = statIdentity_q + 16'd1;
        end
    end

    // Counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            statIssued_q   <= '0;
            statIdentity_q <= '0;
        end else begin
            statIssued_q   <= statIssued_d;
            statIdentity_q <= statIdentity_d;
        end
    end

    assign stat_issued   = statIssued_q;
    assign stat_identity = statIdentity_q;
`endif

endmodule

// File: tb/tb_swap_scheduler.sv
// Testbench tb_swap_scheduler
// Directed vector table for the documented scenarios, hand sequences for
// full/flush/preemption corners, then randomized traffic compared each
// cycle against a queue-based reference model of the scheduler.
// Honours SWAP_SCHED_STATS_EN when the design is built with it.
module tb_swap_scheduler;

    localparam int DEPTH = 4;

    typedef struct packed {
        logic [1:0] a;
        logic [1:0] b;
    } cmd_t;

    typedef struct {
        logic       rstBefore;
        logic [1:0] valid;
        logic [1:0] a0, b0, a1, b1;
        logic       cpu;
        logic [1:0] c1, c2;
        logic       fl;
        logic [1:0] expReady;
        logic [2:0] expCount;
        logic       expDo;
        logic [1:0] expR1, expR2;
        logic [7:0] expMap;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] req_valid;
    logic [3:0] req_a, req_b;
    logic [1:0] req_ready;
    logic       cpu_swap;
    logic [1:0] cpu_reg1, cpu_reg2;
    logic       flush;
    logic       doSWAP;
    logic [1:0] swap_reg1, swap_reg2;
    logic [2:0] fifo_count;
    logic       busy;
    logic [7:0] map_flat;
`ifdef SWAP_SCHED_STATS_EN
    logic [15:0] stat_issued, stat_identity;
`endif

    int compared   = 0;
    int mismatched = 0;

    // Reference model state
    cmd_t       mq[$];
    int         mRr;
    logic       mDo;
    logic [1:0] mR1, mR2;
    logic [1:0] mMap[4];
    int         mIssued, mIdent;
    logic [1:0] lastReady;

    vec_t vecs[11];

    always #5 clk = ~clk;

    swap_scheduler dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_ready  (req_ready),
        .cpu_swap   (cpu_swap),
        .cpu_reg1   (cpu_reg1),
        .cpu_reg2   (cpu_reg2),
        .flush      (flush),
        .doSWAP     (doSWAP),
        .swap_reg1  (swap_reg1),
        .swap_reg2  (swap_reg2),
        .fifo_count (fifo_count),
        .busy       (busy),
        .map_flat   (map_flat)
`ifdef SWAP_SCHED_STATS_EN
        ,
        .stat_issued   (stat_issued),
        .stat_identity (stat_identity)
`endif
    );

    function automatic logic [7:0] modelMap();
        return {mMap[3], mMap[2], mMap[1], mMap[0]};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    task automatic modelReset();
        mq.delete();
        mRr = 0;
        mDo = 1'b0;
        mR1 = 2'd0;
        mR2 = 2'd0;
        for (int i = 0; i < 4; i++) mMap[i] = 2'(i);
        mIssued = 0;
        mIdent  = 0;
    endtask

    // Pulses reset, checks the asynchronous reset state, releases it.
    task automatic doReset();
        req_valid = 2'b00; req_a = '0; req_b = '0;
        cpu_swap = 1'b0; cpu_reg1 = '0; cpu_reg2 = '0; flush = 1'b0;
        reset = 1'b1;
        #2;
        checkOutput("rst_doSWAP", {31'd0, doSWAP}, 32'd0);
        checkOutput("rst_count", {29'd0, fifo_count}, 32'd0);
        checkOutput("rst_map", {24'd0, map_flat}, 32'hE4);
        checkOutput("rst_reg1", {30'd0, swap_reg1}, 32'd0);
        checkOutput("rst_reg2", {30'd0, swap_reg2}, 32'd0);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        modelReset();
        @(posedge clk);
        #1;
    endtask

    // Drives one cycle of inputs, checks ready against the model, advances
    // the model across the edge and checks every registered output.
    task automatic applyStimulus(input logic [1:0] v, input logic [1:0] a0, input logic [1:0] b0,
                                 input logic [1:0] a1, input logic [1:0] b1, input logic cpu,
                                 input logic [1:0] c1, input logic [1:0] c2, input logic fl);
        int         g;
        logic [1:0] expReady;
        cmd_t       head;
        cmd_t       incoming;
        logic [1:0] t;
        req_valid = v; req_a = {a1, a0}; req_b = {b1, b0};
        cpu_swap = cpu; cpu_reg1 = c1; cpu_reg2 = c2; flush = fl;
        #1;
        g = -1;
        if (v[mRr]) g = mRr;
        else if (v[1-mRr]) g = 1 - mRr;
        expReady = 2'b00;
        if (g >= 0 && mq.size() < DEPTH && !fl) expReady[g] = 1'b1;
        lastReady = req_ready;
        checkOutput("req_ready", {30'd0, req_ready}, {30'd0, expReady});
        incoming = (g == 1) ? cmd_t'({a1, b1}) : cmd_t'({a0, b0});
        @(posedge clk);
        if (mDo) begin
            t = mMap[mR1]; mMap[mR1] = mMap[mR2]; mMap[mR2] = t;
        end
        if (cpu) begin
            mDo = 1'b1; mR1 = c1; mR2 = c2;
        end else if (!fl && mq.size() > 0) begin
            head = mq.pop_front();
            mDo = 1'b1; mR1 = head.a; mR2 = head.b;
        end else begin
            mDo = 1'b0;
        end
        if (fl) begin
            mq.delete();
        end else if (expReady != 2'b00) begin
            if (incoming.a != incoming.b) mq.push_back(incoming);
            else if (mIdent < 65535) mIdent++;
        end
        if (expReady != 2'b00) mRr = 1 - g;
        if (mDo && mIssued < 65535) mIssued++;
        #1;
        checkOutput("doSWAP", {31'd0, doSWAP}, {31'd0, mDo});
        checkOutput("swap_reg1", {30'd0, swap_reg1}, {30'd0, mR1});
        checkOutput("swap_reg2", {30'd0, swap_reg2}, {30'd0, mR2});
        checkOutput("fifo_count", {29'd0, fifo_count}, 32'(mq.size()));
        checkOutput("map_flat", {24'd0, map_flat}, {24'd0, modelMap()});
        checkOutput("busy", {31'd0, busy}, {31'd0, (mq.size() != 0) || mDo});
`ifdef SWAP_SCHED_STATS_EN
        checkOutput("stat_issued", {16'd0, stat_issued}, 32'(mIssued));
        checkOutput("stat_identity", {16'd0, stat_identity}, 32'(mIdent));
`endif
    endtask

    initial begin
        logic [1:0] rv;
        logic [1:0] ra0, rb0, ra1, rb1, rc1, rc2;
        logic       rcpu, rfl;

        // rst, valid, a0,b0,a1,b1, cpu,c1,c2, flush | ready, count, do, r1, r2, map
        vecs[0]  = '{1'b0, 2'b01, 2'd1, 2'd3, 2'd0, 2'd0, 1'b0, 2'd0, 2'd0, 1'b0, 2'b01, 3'd1, 1'b0, 2'd0, 2'd0, 8'hE4};
        vecs[1]  = '{1'b0, 2'b00, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 2'd0, 2'd0, 1'b0, 2'b00, 3'd0, 1'b1, 2'd1, 2'd3, 8'hE4};
        vecs[2]  = '{1'b0, 2'b00, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 2'd0, 2'd0, 1'b0, 2'b00, 3'd0, 1'b0, 2'd1, 2'd3, 8'h6C};
        vecs[3]  = '{1'b1, 2'b11, 2'd0, 2'd1, 2'd2, 2'd3, 1'b0, 2'd0, 2'd0, 1'b0, 2'b01, 3'd1, 1'b0, 2'd0, 2'd0, 8'hE4};
        vecs[4]  = '{1'b0, 2'b11, 2'd0, 2'd1, 2'd2, 2'd3, 1'b0, 2'd0, 2'd0, 1'b0, 2'b10, 3'd1, 1'b1, 2'd0, 2'd1, 8'hE4};
        vecs[5]  = '{1'b0, 2'b11, 2'd0, 2'd1, 2'd2, 2'd3, 1'b0, 2'd0, 2'd0, 1'b0, 2'b01, 3'd1, 1'b1, 2'd2, 2'd3, 8'hE1};
        vecs[6]  = '{1'b0, 2'b11, 2'd0, 2'd1, 2'd2, 2'd3, 1'b0, 2'd0, 2'd0, 1'b0, 2'b10, 3'd1, 1'b1, 2'd0, 2'd1, 8'hB1};
        vecs[7]  = '{1'b0, 2'b00, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 2'd0, 2'd0, 1'b0, 2'b00, 3'd0, 1'b1, 2'd2, 2'd3, 8'hB4};
        vecs[8]  = '{1'b0, 2'b00, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 2'd0, 2'd0, 1'b0, 2'b00, 3'd0, 1'b0, 2'd2, 2'd3, 8'hE4};
        vecs[9]  = '{1'b0, 2'b01, 2'd2, 2'd2, 2'd0, 2'd0, 1'b0, 2'd0, 2'd0, 1'b0, 2'b01, 3'd0, 1'b0, 2'd2, 2'd3, 8'hE4};
        vecs[10] = '{1'b0, 2'b00, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 2'd0, 2'd0, 1'b0, 2'b00, 3'd0, 1'b0, 2'd2, 2'd3, 8'hE4};

        doReset();

        for (int i = 0; i < 11; i++) begin
            if (vecs[i].rstBefore) doReset();
            applyStimulus(vecs[i].valid, vecs[i].a0, vecs[i].b0, vecs[i].a1, vecs[i].b1,
                          vecs[i].cpu, vecs[i].c1, vecs[i].c2, vecs[i].fl);
            checkOutput($sformatf("vec%0d_ready", i), {30'd0, lastReady}, {30'd0, vecs[i].expReady});
            checkOutput($sformatf("vec%0d_count", i), {29'd0, fifo_count}, {29'd0, vecs[i].expCount});
            checkOutput($sformatf("vec%0d_do", i), {31'd0, doSWAP}, {31'd0, vecs[i].expDo});
            checkOutput($sformatf("vec%0d_reg1", i), {30'd0, swap_reg1}, {30'd0, vecs[i].expR1});
            checkOutput($sformatf("vec%0d_reg2", i), {30'd0, swap_reg2}, {30'd0, vecs[i].expR2});
            checkOutput($sformatf("vec%0d_map", i), {24'd0, map_flat}, {24'd0, vecs[i].expMap});
        end

        // Decode preempts a FIFO holding three entries; count must hold.
        doReset();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(2'b01, 2'd1, 2'd2, 2'd0, 2'd0, 1'b1, 2'd3, 2'd3, 1'b0);
        end
        checkOutput("pre_count3", {29'd0, fifo_count}, 32'd3);
        applyStimulus(2'b00, 2'd0, 2'd0, 2'd0, 2'd0, 1'b1, 2'd0, 2'd2, 1'b0);
        checkOutput("cpu_count_held", {29'd0, fifo_count}, 32'd3);
        checkOutput("cpu_do", {31'd0, doSWAP}, 32'd1);
        checkOutput("cpu_reg1", {30'd0, swap_reg1}, 32'd0);
        checkOutput("cpu_reg2", {30'd0, swap_reg2}, 32'd2);

        // Full FIFO: ready low even while a pop frees a slot that cycle.
        applyStimulus(2'b01, 2'd1, 2'd3, 2'd0, 2'd0, 1'b1, 2'd3, 2'd3, 1'b0);
        checkOutput("full_count4", {29'd0, fifo_count}, 32'd4);
        applyStimulus(2'b11, 2'd1, 2'd3, 2'd2, 2'd0, 1'b0, 2'd0, 2'd0, 1'b0);
        checkOutput("full_ready_pop", {30'd0, lastReady}, 32'd0);
        checkOutput("full_after_pop", {29'd0, fifo_count}, 32'd3);

        // Refill, then flush: queue empties, no pop, map only follows the
        // swap already in flight (an a==b one here).
        applyStimulus(2'b01, 2'd2, 2'd1, 2'd0, 2'd0, 1'b1, 2'd3, 2'd3, 1'b0);
        checkOutput("refill_count4", {29'd0, fifo_count}, 32'd4);
        applyStimulus(2'b11, 2'd1, 2'd3, 2'd2, 2'd0, 1'b0, 2'd0, 2'd0, 1'b1);
        checkOutput("flush_ready", {30'd0, lastReady}, 32'd0);
        checkOutput("flush_count", {29'd0, fifo_count}, 32'd0);
        checkOutput("flush_no_pop", {31'd0, doSWAP}, 32'd0);
        checkOutput("flush_map", {24'd0, map_flat}, 32'hD2);
        applyStimulus(2'b00, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 2'd0, 2'd0, 1'b0);
        checkOutput("idle_busy", {31'd0, busy}, 32'd0);

        // Flush together with a decode swap: the decode swap still issues.
        applyStimulus(2'b01, 2'd0, 2'd3, 2'd0, 2'd0, 1'b1, 2'd1, 2'd2, 1'b0);
        applyStimulus(2'b00, 2'd0, 2'd0, 2'd0, 2'd0, 1'b1, 2'd0, 2'd3, 1'b1);
        checkOutput("flushcpu_do", {31'd0, doSWAP}, 32'd1);
        checkOutput("flushcpu_count", {29'd0, fifo_count}, 32'd0);

        // Randomized traffic with one reset dropped in mid-stream.
        for (int n = 0; n < 600; n++) begin
            if (n == 300) doReset();
            rv   = 2'($urandom_range(0, 3));
            ra0  = 2'($urandom_range(0, 3));
            rb0  = 2'($urandom_range(0, 3));
            ra1  = 2'($urandom_range(0, 3));
            rb1  = 2'($urandom_range(0, 3));
            rc1  = 2'($urandom_range(0, 3));
            rc2  = 2'($urandom_range(0, 3));
            rcpu = ($urandom_range(0, 9) < 4);
            rfl  = ($urandom_range(0, 24) == 0);
            applyStimulus(rv, ra0, rb0, ra1, rb1, rcpu, rc1, rc2, rfl);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
